// File: rtl/uart_rcv_param.sv
// Parameterised UART receiver: 2-flop synchronised line, mid-bit sampling,
// optional parity, 1 or 2 stop bits, single-word hold register with
// full/ack handshake, parity/frame error flags and sticky overrun.
module uart_rcv_param #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 10000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] parallel_out,
  output logic                 full,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS + 1);
  localparam int IDX_W     = 4;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_DATA   = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic             LAST_STOP   = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic             ODD_REQ     = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_nextCount;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bitIdx;
  logic                 r_stopIdx;
  logic                 r_frameBad;
  logic                 r_parBad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_full;
  logic                 r_parityErr;
  logic                 r_frameErr;
  logic                 r_overrun;

  logic w_serialS;
  logic w_tick;
  logic w_sampleData;
  logic w_samplePar;
  logic w_sampleStop;
  logic w_done;
  logic w_frameNow;
  logic w_parityMismatch;

  assign w_serialS        = r_sync2;
  assign w_tick           = (r_count == '0);
  assign w_frameNow       = r_frameBad | ~w_serialS;
  assign w_parityMismatch = ((^r_shift) ^ w_serialS) != ODD_REQ;

  assign parallel_out = r_data;
  assign full         = r_full;
  assign parity_err   = r_parityErr;
  assign frame_err    = r_frameErr;
  assign overrun      = r_overrun;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state and bit-timing counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Next-state, counter reload and sampling strobes for each frame phase.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_sampleData = 1'b0;
    w_samplePar  = 1'b0;
    w_sampleStop = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_serialS) begin
          w_nextState = START;
          w_nextCount = HALF_RELOAD;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_serialS) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = DATA;
            w_nextCount = BIT_RELOAD;
          end
        end else begin
          w_nextCount = r_count - CNT_ONE;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_sampleData = 1'b1;
          w_nextCount  = BIT_RELOAD;
          if (r_bitIdx == LAST_DATA) begin
            w_nextState = (PARITY != 0) ? PAR : STOP;
          end
        end else begin
          w_nextCount = r_count - CNT_ONE;
        end
      end
      PAR: begin
        if (w_tick) begin
          w_samplePar = 1'b1;
          w_nextCount = BIT_RELOAD;
          w_nextState = STOP;
        end else begin
          w_nextCount = r_count - CNT_ONE;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_sampleStop = 1'b1;
          if (r_stopIdx == LAST_STOP) begin
            w_done      = 1'b1;
            w_nextState = w_frameNow ? BREAK : IDLE;
          end else begin
            w_nextCount = BIT_RELOAD;
          end
        end else begin
          w_nextCount = r_count - CNT_ONE;
        end
      end
      BREAK: begin
        if (w_serialS) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Frame datapath: data shift register, bit/stop indices, error accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bitIdx   <= '0;
      r_stopIdx  <= 1'b0;
      r_frameBad <= 1'b0;
      r_parBad   <= 1'b0;
    end else begin
      if (w_sampleData) begin
        r_shift <= {w_serialS, r_shift[DATA_BITS-1:1]};
      end
      if (r_state == START) begin
        r_bitIdx <= '0;
        r_parBad <= 1'b0;
      end else begin
        if (w_sampleData) begin
          r_bitIdx <= r_bitIdx + IDX_ONE;
        end
        if (w_samplePar) begin
          r_parBad <= w_parityMismatch;
        end
      end
      if (r_state != STOP) begin
        r_stopIdx  <= 1'b0;
        r_frameBad <= 1'b0;
      end else if (w_sampleStop) begin
        r_stopIdx <= 1'b1;
        if (!w_serialS) begin
          r_frameBad <= 1'b1;
        end
      end
    end
  end

  // Hold register and handshake: load on completion when free or acked, else overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_full      <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done) begin
        if (!r_full || ack) begin
          r_data      <= r_shift;
          r_parityErr <= r_parBad;
          r_frameErr  <= w_frameNow;
          r_full      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (ack && r_full) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rcv_param.sv
// Testbench for uart_rcv_param: an 8N1 receiver and an 8E2 receiver driven
// with directed frames; a cycle-level frame model predicts every output.
module tb_uart_rcv_param;

  localparam int TB_CLK_HZ = 16;
  localparam int TB_BAUD   = 1;
  localparam int BITC      = TB_CLK_HZ / TB_BAUD;
  localparam int HALFC     = BITC / 2;
  localparam int PARITY_B  = 2;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         pe;
    bit         fe;
  } entry_t;

  logic       clk;
  logic       reset;
  logic       serialA;
  logic       serialB;
  logic       ackA;
  logic       ackB;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       fullA, peA, feA, ovrA;
  logic       fullB, peB, feB, ovrB;

  int nCompared = 0;
  int nFailed   = 0;
  int cyc       = 0;
  int startA    = 0;

  entry_t     pendA[$];
  entry_t     pendB[$];
  bit         expFull[2];
  bit         expPe[2];
  bit         expFe[2];
  bit         expOvr[2];
  logic [7:0] expData[2];

  uart_rcv_param #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .reset(reset), .serial_in(serialA), .ack(ackA),
    .parallel_out(dataA), .full(fullA), .parity_err(peA), .frame_err(feA), .overrun(ovrA)
  );

  uart_rcv_param #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD), .DATA_BITS(8), .PARITY(PARITY_B), .STOP_BITS(2)) dutB (
    .clk(clk), .reset(reset), .serial_in(serialB), .ack(ackB),
    .parallel_out(dataB), .full(fullB), .parity_err(peB), .frame_err(feB), .overrun(ovrB)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      if (nFailed <= 20) $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One word-level step of the receiver model for receiver d.
  task automatic modelStep(input int d, input bit hit, input entry_t e, input bit ackIn);
    if (hit) begin
      if (!expFull[d] || ackIn) begin
        expData[d] = e.data;
        expPe[d]   = e.pe;
        expFe[d]   = e.fe;
        expFull[d] = 1'b1;
      end else begin
        expOvr[d] = 1'b1;
      end
    end else if (ackIn && expFull[d]) begin
      expFull[d] = 1'b0;
    end
  endtask

  // Model: frames complete at predicted cycles; ack/full/overrun word rules.
  always @(posedge clk or posedge reset) begin
    entry_t e;
    bit hit;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        expFull[d] = 1'b0; expPe[d] = 1'b0; expFe[d] = 1'b0; expOvr[d] = 1'b0; expData[d] = 8'h00;
      end
      pendA.delete();
      pendB.delete();
    end else begin
      cyc++;
      hit = (pendA.size() > 0) && (pendA[0].cyc == cyc);
      e = '{0, 8'h00, 1'b0, 1'b0};
      if (hit) e = pendA.pop_front();
      modelStep(0, hit, e, ackA);
      hit = (pendB.size() > 0) && (pendB[0].cyc == cyc);
      e = '{0, 8'h00, 1'b0, 1'b0};
      if (hit) e = pendB.pop_front();
      modelStep(1, hit, e, ackB);
    end
  end

  // Compare every output of both receivers against the model each cycle.
  always @(negedge clk) begin
    checkOutput("A.full",   32'(fullA), 32'(expFull[0]));
    checkOutput("A.data",   32'(dataA), 32'(expData[0]));
    checkOutput("A.parity", 32'(peA),   32'(expPe[0]));
    checkOutput("A.frame",  32'(feA),   32'(expFe[0]));
    checkOutput("A.ovr",    32'(ovrA),  32'(expOvr[0]));
    checkOutput("B.full",   32'(fullB), 32'(expFull[1]));
    checkOutput("B.data",   32'(dataB), 32'(expData[1]));
    checkOutput("B.parity", 32'(peB),   32'(expPe[1]));
    checkOutput("B.frame",  32'(feB),   32'(expFe[1]));
    checkOutput("B.ovr",    32'(ovrB),  32'(expOvr[1]));
  end

  task automatic setLine(input int which, input bit v);
    if (which == 0) serialA = v;
    else serialB = v;
  endtask

  // Send one frame; lastLen shortens the final bit; abortAt>=0 resets mid-frame at that bit.
  task automatic applyStimulus(input int which, input logic [7:0] data, input bit parBit,
                               input bit stop0, input bit stop1, input int lastLen, input int abortAt);
    bit     bits[$];
    entry_t e;
    bit     hasPar;
    int     nStop;
    int     len;
    hasPar = (which == 1);
    nStop  = (which == 1) ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (hasPar) bits.push_back(parBit);
    bits.push_back(stop0);
    if (nStop == 2) bits.push_back(stop1);
    @(posedge clk);
    #1;
    if (which == 0) startA = cyc;
    if (abortAt < 0) begin
      e.cyc  = cyc + 3 + HALFC + BITC * (bits.size() - 1);
      e.data = data;
      e.pe   = hasPar && ((($countones(data) + int'(parBit)) % 2) != ((PARITY_B == 1) ? 1 : 0));
      e.fe   = (stop0 == 1'b0) || ((nStop == 2) && (stop1 == 1'b0));
      if (which == 0) pendA.push_back(e);
      else pendB.push_back(e);
    end
    for (int i = 0; i < bits.size(); i++) begin
      len = (i == bits.size() - 1) ? lastLen : BITC;
      if (i == abortAt) len = BITC / 2;
      setLine(which, bits[i]);
      repeat (len) @(posedge clk);
      #1;
      if (i == abortAt) begin
        setLine(which, 1'b1);
        reset = 1'b1;
        #2;
        checkOutput("rst.A.full", 32'(fullA), 32'd0);
        checkOutput("rst.A.data", 32'(dataA), 32'd0);
        checkOutput("rst.A.ovr",  32'(ovrA),  32'd0);
        checkOutput("rst.B.full", 32'(fullB), 32'd0);
        checkOutput("rst.B.data", 32'(dataB), 32'd0);
        checkOutput("rst.B.ovr",  32'(ovrB),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
    end
  endtask

  task automatic applyAck(input int which);
    @(posedge clk);
    #1;
    if (which == 0) ackA = 1'b1; else ackB = 1'b1;
    @(posedge clk);
    #1;
    ackA = 1'b0;
    ackB = 1'b0;
  endtask

  // Raise ack so that it is sampled on the same edge the newest pending frame completes.
  task automatic ackAt(input int which);
    int target;
    bit found;
    target = 0;
    found  = 1'b0;
    for (int g = 0; g < 50 && !found; g++) begin
      @(posedge clk);
      #2;
      if (which == 0 && pendA.size() > 0) begin target = pendA[pendA.size()-1].cyc; found = 1'b1; end
      if (which == 1 && pendB.size() > 0) begin target = pendB[pendB.size()-1].cyc; found = 1'b1; end
    end
    if (!found) begin
      checkOutput("ackAt.pending", 32'd0, 32'd1);
      return;
    end
    for (int g = 0; g < 1000 && cyc < target - 1; g++) begin
      @(posedge clk);
      #1;
    end
    if (which == 0) ackA = 1'b1; else ackB = 1'b1;
    @(posedge clk);
    #1;
    ackA = 1'b0;
    ackB = 1'b0;
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    int seen;
    reset   = 1'b1;
    serialA = 1'b1;
    serialB = 1'b1;
    ackA    = 1'b0;
    ackB    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset.fullA", 32'(fullA), 32'd0);
    checkOutput("reset.dataA", 32'(dataA), 32'd0);
    repeat (5) @(posedge clk);

    // 8N1 0xA5 with completion latency measured from the start edge
    seen = 0;
    fork
      applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1, BITC, -1);
      begin
        @(posedge clk);
        #2;
        for (int g = 0; g < 400 && seen == 0; g++) begin
          @(negedge clk);
          if (fullA) seen = cyc - startA;
        end
        checkOutput("A5.latency", 32'(seen), 32'd155);
      end
    join
    checkOutput("A5.data", 32'(dataA), 32'hA5);
    checkOutput("A5.full", 32'(fullA), 32'd1);
    checkOutput("A5.err",  32'({peA, feA}), 32'd0);
    applyAck(0);
    checkOutput("A5.ackFull", 32'(fullA), 32'd0);
    checkOutput("A5.stable",  32'(dataA), 32'hA5);

    // ack while empty, then a short glitch on the idle line
    applyAck(0);
    @(posedge clk);
    #1 serialA = 1'b0;
    repeat (4) @(posedge clk);
    #1 serialA = 1'b1;
    repeat (40) @(posedge clk);
    #1 checkOutput("glitch.full", 32'(fullA), 32'd0);

    // even parity: wrong then right parity bit
    applyStimulus(1, 8'h03, 1'b1, 1'b1, 1'b1, BITC, -1);
    checkOutput("par1.err",  32'(peB),   32'd1);
    checkOutput("par1.data", 32'(dataB), 32'h03);
    applyAck(1);
    applyStimulus(1, 8'h03, 1'b0, 1'b1, 1'b1, BITC, -1);
    checkOutput("par0.err",  32'(peB),   32'd0);
    applyAck(1);

    // second stop bit low on the two-stop receiver
    applyStimulus(1, 8'h81, 1'b0, 1'b1, 1'b0, BITC, -1);
    serialB = 1'b1;
    checkOutput("stop2.frame", 32'(feB),   32'd1);
    checkOutput("stop2.data",  32'(dataB), 32'h81);
    applyAck(1);

    // break: stop low then line held low for 40 bit times
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, BITC, -1);
    repeat (40 * BITC) @(posedge clk);
    #1;
    checkOutput("brk.frame", 32'(feA),   32'd1);
    checkOutput("brk.data",  32'(dataA), 32'h3C);
    checkOutput("brk.ovr",   32'(ovrA),  32'd0);
    serialA = 1'b1;
    repeat (20) @(posedge clk);
    applyAck(0);
    applyStimulus(0, 8'h96, 1'b0, 1'b1, 1'b1, BITC, -1);
    checkOutput("postbrk.data",  32'(dataA), 32'h96);
    checkOutput("postbrk.frame", 32'(feA),   32'd0);
    applyAck(0);

    // back-to-back frames without ack (short stop bit -> start in first idle cycle)
    applyStimulus(0, 8'h11, 1'b0, 1'b1, 1'b1, 8, -1);
    applyStimulus(0, 8'h22, 1'b0, 1'b1, 1'b1, BITC, -1);
    checkOutput("ovr.data", 32'(dataA), 32'h11);
    checkOutput("ovr.flag", 32'(ovrA),  32'd1);

    // ack coinciding with completion while full
    fork
      applyStimulus(0, 8'h33, 1'b0, 1'b1, 1'b1, BITC, -1);
      ackAt(0);
    join
    checkOutput("coinA.data", 32'(dataA), 32'h33);
    checkOutput("coinA.full", 32'(fullA), 32'd1);
    applyStimulus(1, 8'h44, 1'b0, 1'b1, 1'b1, BITC, -1);
    fork
      applyStimulus(1, 8'h55, 1'b0, 1'b1, 1'b1, BITC, -1);
      ackAt(1);
    join
    checkOutput("coinB.data", 32'(dataB), 32'h55);
    checkOutput("coinB.full", 32'(fullB), 32'd1);
    checkOutput("coinB.ovr",  32'(ovrB),  32'd0);

    // reset during data bit 4, then a clean frame
    applyStimulus(0, 8'hC3, 1'b0, 1'b1, 1'b1, BITC, 5);
    repeat (10) @(posedge clk);
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 1'b1, BITC, -1);
    checkOutput("post.data", 32'(dataA), 32'h5A);
    checkOutput("post.full", 32'(fullA), 32'd1);
    checkOutput("post.err",  32'({peA, feA, ovrA}), 32'd0);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
